// File: rtl/window_3x3_generator.sv
// window_3x3_generator
//
// Builds a sliding 3x3 pixel window from a stream of vertical pixel triplets.
// Each accepted triplet is one column of three stacked rows (the line buffers
// upstream supply them). Three 3-deep shift registers hold the latest three
// columns. A registered window is emitted once three columns of the current
// row are present, so a window never straddles two rows.
//
// Parameters
//   IMG_WIDTH  : pixels per row (3..65535)
//   FRAME_ROWS : triplet rows per frame (1..65535)
//   FIRST_ROW  : triplet rows below this index emit no window (line-buffer priming)
//
// Ports
//   clk             : rising-edge clock
//   rst             : synchronous, active-low reset
//   input_pixel_1   : newest row pixel (window bottom row)
//   input_pixel_2   : previous row pixel (window middle row)
//   input_pixel_3   : oldest row pixel (window top row)
//   input_is_valid  : triplet accepted this cycle
//   window_out      : P(r,c) at bits [24k+23:24k], k = 3r+c, r=0 top, c=0 oldest column
//   output_is_valid : window_out / out_row / out_col valid this cycle
//   out_row         : triplet row index of the window
//   out_col         : column index of the window centre
//   frame_done      : one-cycle pulse alongside the last window of a frame

module window_3x3_generator #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned FRAME_ROWS = 512,
  parameter int unsigned FIRST_ROW  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [23:0]  input_pixel_1,
  input  logic [23:0]  input_pixel_2,
  input  logic [23:0]  input_pixel_3,
  input  logic         input_is_valid,
  output logic [215:0] window_out,
  output logic         output_is_valid,
  output logic [15:0]  out_row,
  output logic [15:0]  out_col,
  output logic         frame_done
);

  localparam logic [15:0] LastCol  = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LastRow  = 16'(FRAME_ROWS - 1);
  localparam logic [16:0] FirstRow = 17'(FIRST_ROW);

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [15:0] col_cnt_q, col_cnt_d;
  logic [15:0] row_cnt_q, row_cnt_d;

  // Index [0] is the oldest (leftmost) column, [2] the newest.
  logic [2:0][23:0] top_q, top_d;
  logic [2:0][23:0] mid_q, mid_d;
  logic [2:0][23:0] bot_q, bot_d;

  logic [215:0] window_q, window_d;
  logic         out_valid_q;
  logic [15:0]  out_row_q, out_row_d;
  logic [15:0]  out_col_q, out_col_d;
  logic         frame_done_q;

  logic [15:0] cur_col;
  logic [15:0] cur_row;
  logic        last_col;
  logic        end_frame;
  logic        row_ok;
  logic        emit;
  logic        accept;

  assign accept = input_is_valid;

  always_comb begin
    // Outside ACTIVE the incoming triplet always starts a new frame at (0,0).
    cur_col = (state_q == StActive) ? col_cnt_q : 16'd0;
    cur_row = (state_q == StActive) ? row_cnt_q : 16'd0;

    last_col  = (cur_col == LastCol);
    end_frame = last_col && (cur_row == LastRow);

    // row >= FIRST_ROW written as row + 1 > FIRST_ROW so FIRST_ROW = 0 is not
    // a degenerate unsigned compare.
    row_ok = ({1'b0, cur_row} + 17'd1) > FirstRow;
    emit   = (cur_col >= 16'd2) && row_ok;

    // Shift left: new pixel lands in column 2.
    top_d = {input_pixel_3, top_q[2], top_q[1]};
    mid_d = {input_pixel_2, mid_q[2], mid_q[1]};
    bot_d = {input_pixel_1, bot_q[2], bot_q[1]};

    window_d  = {bot_d, mid_d, top_d};
    out_row_d = cur_row;
    out_col_d = cur_col - 16'd1;

    if (end_frame) begin
      col_cnt_d = 16'd0;
      row_cnt_d = 16'd0;
    end else if (last_col) begin
      col_cnt_d = 16'd0;
      row_cnt_d = cur_row + 16'd1;
    end else begin
      col_cnt_d = cur_col + 16'd1;
      row_cnt_d = cur_row;
    end

    state_d = state_q;
    if (accept) begin
      state_d = end_frame ? StDone : StActive;
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      window_q     <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= accept && emit;
      frame_done_q <= accept && end_frame;
      if (accept) begin
        col_cnt_q <= col_cnt_d;
        row_cnt_q <= row_cnt_d;
        top_q     <= top_d;
        mid_q     <= mid_d;
        bot_q     <= bot_d;
        window_q  <= window_d;
        out_row_q <= out_row_d;
        out_col_q <= out_col_d;
      end
    end
  end

  assign window_out      = window_q;
  assign output_is_valid = out_valid_q;
  assign out_row         = out_row_q;
  assign out_col         = out_col_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_window_3x3_generator.sv
// Bench for window_3x3_generator. Two instances share the stimulus: one with
// FIRST_ROW = 0, one with FIRST_ROW = 1. A reference model tracks the frame
// position as a plain triplet count and keeps the current row's pixels in
// arrays, deriving each expected window from them.

module tb_window_3x3_generator;

  localparam int W = 4;
  localparam int R = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  p1, p2, p3;
  logic         vin;

  logic [215:0] win0, win1;
  logic         v0, v1, fd0, fd1;
  logic [15:0]  row0, col0, row1, col1;

  always #5 clk = ~clk;

  window_3x3_generator #(.IMG_WIDTH(W), .FRAME_ROWS(R), .FIRST_ROW(0)) dut0 (
    .clk            (clk),
    .rst            (rst),
    .input_pixel_1  (p1),
    .input_pixel_2  (p2),
    .input_pixel_3  (p3),
    .input_is_valid (vin),
    .window_out     (win0),
    .output_is_valid(v0),
    .out_row        (row0),
    .out_col        (col0),
    .frame_done     (fd0)
  );

  window_3x3_generator #(.IMG_WIDTH(W), .FRAME_ROWS(R), .FIRST_ROW(1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .input_pixel_1  (p1),
    .input_pixel_2  (p2),
    .input_pixel_3  (p3),
    .input_is_valid (vin),
    .window_out     (win1),
    .output_is_valid(v1),
    .out_row        (row1),
    .out_col        (col1),
    .frame_done     (fd1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  task automatic check_eq(input string tag, input logic [215:0] got, input logic [215:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int unsigned pos = 0;  // triplets accepted so far in the current frame
  logic [23:0] h1[W];
  logic [23:0] h2[W];
  logic [23:0] h3[W];

  function automatic logic [23:0] pix(input int row, input int col, input int lane);
    return {8'(lane), 8'(row), 8'(col)};
  endfunction

  // One clock: drive at negedge, predict, sample 1 time unit after posedge.
  task automatic step(input logic v, input logic r_n,
                      input logic [23:0] a1, input logic [23:0] a2, input logic [23:0] a3);
    logic         e_rst, e_v0, e_v1, e_done;
    logic [215:0] e_win;
    logic [15:0]  e_row, e_col;
    int           row, col;
    @(negedge clk);
    rst = r_n;
    vin = v;
    p1  = a1;
    p2  = a2;
    p3  = a3;
    e_rst = !r_n;
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    e_done = 1'b0;
    e_win = '0;
    e_row = '0;
    e_col = '0;
    if (!r_n) begin
      pos = 0;
    end else if (v) begin
      row = int'(pos) / W;
      col = int'(pos) % W;
      h1[col] = a1;
      h2[col] = a2;
      h3[col] = a3;
      if (col >= 2) begin
        for (int c = 0; c < 3; c++) begin
          e_win[24*c +: 24]     = h3[col-2+c];
          e_win[24*(3+c) +: 24] = h2[col-2+c];
          e_win[24*(6+c) +: 24] = h1[col-2+c];
        end
        e_row = 16'(row);
        e_col = 16'(col - 1);
        e_v0  = 1'b1;
        e_v1  = (row >= 1);
      end
      e_done = (pos == W*R - 1);
      pos = (pos + 1) % (W*R);
    end
    @(posedge clk);
    #1;
    if (fd0) done_seen++;
    check_eq("valid0", 216'(v0), 216'(e_v0));
    check_eq("valid1", 216'(v1), 216'(e_v1));
    check_eq("done0", 216'(fd0), 216'(e_done));
    check_eq("done1", 216'(fd1), 216'(e_done));
    if (e_rst) begin
      check_eq("rst_win0", win0, '0);
      check_eq("rst_win1", win1, '0);
      check_eq("rst_row0", 216'(row0), '0);
      check_eq("rst_col0", 216'(col0), '0);
      check_eq("rst_row1", 216'(row1), '0);
      check_eq("rst_col1", 216'(col1), '0);
    end
    if (e_v0) begin
      check_eq("win0", win0, e_win);
      check_eq("row0", 216'(row0), 216'(e_row));
      check_eq("col0", 216'(col0), 216'(e_col));
    end
    if (e_v1) begin
      check_eq("win1", win1, e_win);
      check_eq("row1", 216'(row1), 216'(e_row));
      check_eq("col1", 216'(col1), 216'(e_col));
    end
  endtask

  task automatic feed(input int idx, input int lane_base);
    int r, c;
    r = (idx / W) % R;
    c = idx % W;
    step(1'b1, 1'b1, pix(r, c, lane_base + 1), pix(r, c, lane_base + 2), pix(r, c, lane_base + 3));
  endtask

  initial begin
    rst = 1'b0;
    vin = 1'b0;
    p1  = '0;
    p2  = '0;
    p3  = '0;

    // Reset with a triplet presented: it must be discarded.
    step(1'b1, 1'b0, 24'h111111, 24'h222222, 24'h333333);
    step(1'b0, 1'b0, '0, '0, '0);

    // Two back-to-back frames, continuous valid, pixel = {lane,row,col}.
    for (int i = 0; i < 2 * W * R; i++) feed(i, 16 * (i / (W * R)));
    check_eq("done_count", 216'(done_seen), 216'(2));

    // Same pattern with valid toggling 1/0.
    for (int i = 0; i < 2 * W * R; i++) begin
      if (i % 2 == 0) feed(i / 2, 64);
      else step(1'b0, 1'b1, 24'hdeadbe, 24'hdeadbe, 24'hdeadbe);
    end

    // Reset for one cycle while the (row 1, col 2) triplet is presented.
    for (int i = 0; i < W + 2; i++) feed(i, 96);
    step(1'b1, 1'b0, pix(1, 2, 97), pix(1, 2, 98), pix(1, 2, 99));
    for (int i = 0; i < W * R; i++) feed(i, 128);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 59) != 0),
           24'($urandom), 24'($urandom), 24'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
